// File: rtl/mul_unit.sv
// Iterative 64x64 multiplier (MUL/UMULH/SMULH) between register-file read and write ports.
// Latency 65 edges from the Start capture to the one-cycle Done/RegWr pulse; Start is ignored while Busy.
module mul_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [63:0] BusA,
  input  logic [63:0] BusB,
  input  logic [4:0]  Rd,
  output logic        Busy,
  output logic        Done,
  output logic [63:0] BusW,
  output logic [4:0]  RW,
  output logic        RegWr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_UMULH = 2'b01;
  localparam logic [1:0] OP_SMULH = 2'b10;

  state_t      state_q, state_d;
  logic [63:0] mcand_q, mcand_d;
  logic [63:0] hi_q, hi_d;
  logic [63:0] lo_q, lo_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic        sel_hi_q, sel_hi_d;
  logic [4:0]  rd_q, rd_d;
  logic [63:0] busw_q, busw_d;
  logic [4:0]  rw_q, rw_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        is_smulh;
  logic [63:0] abs_a, abs_b;
  logic [64:0] sum;
  logic [127:0] prod;

  // Signed high multiply runs on magnitudes; 2^63 still fits the unsigned 64-bit datapath.
  always_comb begin
    is_smulh = (Op == OP_SMULH);
    abs_a    = BusA[63] ? (~BusA + 64'd1) : BusA;
    abs_b    = BusB[63] ? (~BusB + 64'd1) : BusB;
    sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : 65'd0);
    prod     = neg_q ? (~{hi_q, lo_q} + 128'd1) : {hi_q, lo_q};
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    sel_hi_d = sel_hi_q;
    rd_d     = rd_q;
    busw_d   = busw_q;
    rw_d     = rw_q;
    busy_d   = busy_q;
    done_d   = done_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (Start) begin
          state_d  = S_RUN;
          busy_d   = 1'b1;
          cnt_d    = 6'd0;
          mcand_d  = is_smulh ? abs_a : BusA;
          lo_d     = is_smulh ? abs_b : BusB;
          hi_d     = 64'd0;
          neg_d    = is_smulh & (BusA[63] ^ BusB[63]);
          sel_hi_d = (Op == OP_UMULH) || is_smulh;
          rd_d     = Rd;
        end
      end

      S_RUN: begin
        // Add-then-shift: the 65th sum bit becomes hi[63] after the shift.
        hi_d  = sum[64:1];
        lo_d  = {sum[0], lo_q[63:1]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd63) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        busw_d  = sel_hi_q ? prod[127:64] : prod[63:0];
        rw_d    = rd_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= 64'd0;
      hi_q     <= 64'd0;
      lo_q     <= 64'd0;
      cnt_q    <= 6'd0;
      neg_q    <= 1'b0;
      sel_hi_q <= 1'b0;
      rd_q     <= 5'd0;
      busw_q   <= 64'd0;
      rw_q     <= 5'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      sel_hi_q <= sel_hi_d;
      rd_q     <= rd_d;
      busw_q   <= busw_d;
      rw_q     <= rw_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Busy  = busy_q;
  assign Done  = done_q;
  assign RegWr = done_q;
  assign BusW  = busw_q;
  assign RW    = rw_q;

endmodule

// File: tb/tb_mul_unit.sv
// Directed bench for mul_unit: results, latency, handshake and reset behaviour.
`timescale 1ns/1ps
module tb_mul_unit;

  logic        Clk = 1'b0;
  logic        Reset, Start;
  logic [1:0]  Op;
  logic [63:0] BusA, BusB;
  logic [4:0]  Rd;
  logic        Busy, Done, RegWr;
  logic [63:0] BusW;
  logic [4:0]  RW;

  int checks = 0;
  int errors = 0;

  mul_unit dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op),
    .BusA(BusA), .BusB(BusB), .Rd(Rd),
    .Busy(Busy), .Done(Done), .BusW(BusW), .RW(RW), .RegWr(RegWr)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, wait (bounded) for Done and check latency, result and pulse width.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd, input logic [63:0] exp);
    int n;
    Op = op; BusA = a; BusB = b; Rd = rd; Start = 1'b1;
    tick();
    Start = 1'b0;
    chk({tag, "_busy"}, {63'd0, Busy}, 64'd1);
    n = 0;
    while (Done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd65);
    chk({tag, "_busw"}, BusW, exp);
    chk({tag, "_rw"}, {59'd0, RW}, {59'd0, rd});
    chk({tag, "_regwr"}, {63'd0, RegWr}, 64'd1);
    tick();
    chk({tag, "_done_clr"}, {63'd0, Done}, 64'd0);
    chk({tag, "_hold"}, BusW, exp);
  endtask

  initial begin
    int n;
    logic seen;
    Reset = 1'b1; Start = 1'b0; Op = 2'b00; BusA = '0; BusB = '0; Rd = '0;
    tick(); tick();
    Reset = 1'b0;
    chk("rst_busy", {63'd0, Busy}, 64'd0);
    chk("rst_done", {63'd0, Done}, 64'd0);
    chk("rst_busw", BusW, 64'd0);
    chk("rst_rw", {59'd0, RW}, 64'd0);

    // MUL 3*5 with operand change after capture and a stray Start during RUN.
    Op = 2'b00; BusA = 64'd3; BusB = 64'd5; Rd = 5'd7; Start = 1'b1;
    tick();                                   // edge 0
    Start = 1'b0;
    chk("hs_busy0", {63'd0, Busy}, 64'd1);
    tick();                                   // edge 1
    BusA = 64'd99; BusB = 64'd1234; Rd = 5'd3; Op = 2'b01;
    for (int e = 2; e <= 64; e++) begin
      Start = (e == 10);
      tick();
      Start = 1'b0;
      if (e == 11) chk("hs_busy11", {63'd0, Busy}, 64'd1);
    end
    chk("hs_busy64", {63'd0, Busy}, 64'd1);
    chk("hs_done64", {63'd0, Done}, 64'd0);
    // Second op presented and held through the DONE cycle.
    Op = 2'b01; BusA = 64'hFFFF_FFFF_FFFF_FFFF; BusB = 64'hFFFF_FFFF_FFFF_FFFF; Rd = 5'd9;
    Start = 1'b1;
    tick();                                   // edge 65
    chk("hs_done65", {63'd0, Done}, 64'd1);
    chk("hs_regwr65", {63'd0, RegWr}, 64'd1);
    chk("hs_busy65", {63'd0, Busy}, 64'd0);
    chk("hs_busw", BusW, 64'd15);
    chk("hs_rw", {59'd0, RW}, 64'd7);
    tick();                                   // edge 66: second op captured
    Start = 1'b0;
    chk("b2b_busy", {63'd0, Busy}, 64'd1);
    chk("b2b_done_clr", {63'd0, Done}, 64'd0);
    n = 0;
    while (Done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("b2b_lat", 64'(n), 64'd65);
    chk("b2b_busw", BusW, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("b2b_rw", {59'd0, RW}, 64'd9);
    tick();

    run_op("mul_ff", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 64'd1);
    run_op("smulh_m1", 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("smulh_min", 2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd2,
           64'h4000_0000_0000_0000);
    run_op("op11", 2'b11, 64'd3, 64'd5, 5'd4, 64'd15);
    run_op("mul_neg", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF);

    // Reset at edge 30 of a running op.
    Op = 2'b00; BusA = 64'd11; BusB = 64'd13; Rd = 5'd6; Start = 1'b1;
    tick();                                   // edge 0
    Start = 1'b0;
    for (int e = 1; e <= 29; e++) tick();
    Reset = 1'b1;
    tick();                                   // edge 30
    Reset = 1'b0;
    chk("midrst_busy", {63'd0, Busy}, 64'd0);
    chk("midrst_busw", BusW, 64'd0);
    chk("midrst_rw", {59'd0, RW}, 64'd0);
    seen = 1'b0;
    for (int e = 0; e < 80; e++) begin
      tick();
      seen = seen | RegWr;
    end
    chk("midrst_no_wr", {63'd0, seen}, 64'd0);
    run_op("after_rst", 2'b00, 64'd6, 64'd7, 5'd8, 64'd42);

    // Reset wins over a simultaneous Start.
    Start = 1'b1; Reset = 1'b1; BusA = 64'd2; BusB = 64'd2;
    tick();
    Start = 1'b0; Reset = 1'b0;
    chk("rststart_busy", {63'd0, Busy}, 64'd0);
    tick();
    chk("rststart_busy2", {63'd0, Busy}, 64'd0);
    chk("rststart_done", {63'd0, Done}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
